shift_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for an area-reduced EX-stage shifter. It shifts STEP bits per cycle instead of using a full 32-bit barrel shifter.
- Accepts one SLL/SRL/SRA request through a valid/ready handshake, iterates the shift, then holds the result until the consumer accepts it.
- Uses the same 4-bit alu_ctrl op encoding as the single-cycle shift unit, so decode and control logic stay unchanged.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_step.sv | 20 ++
 rtl/shift_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_shift_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes, FSM encoding and data width shared by the shift sequencer
package shift_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] SHIFT_OP_SLL = 4'b0101;
  localparam logic [3:0] SHIFT_OP_SRL = 4'b0110;
  localparam logic [3:0] SHIFT_OP_SRA = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == SHIFT_OP_SLL) || (op == SHIFT_OP_SRL) || (op == SHIFT_OP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift of one word by 0..STEP bits with explicit fill bit
module shift_step import shift_pkg::*; #(
  parameter int STEP = 1
) (
  input  logic [3:0]           op_i,
  input  logic                 fill_i,
  input  logic [$clog2(STEP):0] amt_i,
  input  logic [XLEN-1:0]      data_i,
  output logic [XLEN-1:0]      data_o
);

  logic [XLEN-1:0] right;

  // Right shifts OR the fill bit into the vacated top positions (mask is empty for amt 0).
  always_comb begin
    right  = (data_i >> amt_i) | (~({XLEN{1'b1}} >> amt_i) & {XLEN{fill_i}});
    data_o = (op_i == SHIFT_OP_SLL) ? (data_i << amt_i) : right;
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - iterative SLL/SRL/SRA sequencer, STEP bits per cycle
// SHIFT_SEQ_ILLEGAL_FLAG_EN: drive out_illegal for non-shift ops (tied 0 otherwise)
module shift_seq_ctrl import shift_pkg::*; #(
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_data,
  input  logic [4:0]      in_shamt,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_illegal
);

  localparam int AW = $clog2(STEP) + 1;
  localparam logic [4:0]    STEP_REM = 5'(STEP);
  localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

  shift_state_e    state_q, state_d;
  logic [XLEN-1:0] data_q, data_d, step_data;
  logic [3:0]      op_q, op_d;
  logic [4:0]      rem_q, rem_d, rem_left;
  logic            sign_q, sign_d;
  logic [AW-1:0]   amt;
  logic            fill;
  logic            accept;

  assign in_ready  = (state_q == IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

  // Last iteration may move fewer than STEP bits.
  assign amt      = (rem_q < STEP_REM) ? rem_q[AW-1:0] : STEP_AMT;
  assign rem_left = rem_q - 5'(amt);
  assign fill     = (op_q == SHIFT_OP_SRA) && sign_q;

  shift_step #(.STEP(STEP)) u_step (
    .op_i   (op_q),
    .fill_i (fill),
    .amt_i  (amt),
    .data_i (data_q),
    .data_o (step_data)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    if (flush) begin
      state_d = IDLE;
      data_d  = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d   = in_op;
            sign_d = in_data[XLEN-1];
            rem_d  = in_shamt;
            data_d = in_data;
            if (!is_shift_op(in_op)) begin
              data_d  = '0;
              rem_d   = '0;
              state_d = DONE;
            end else if (in_shamt == 5'd0) begin
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        SHIFT: begin
          data_d = step_data;
          rem_d  = rem_left;
          if (rem_left == 5'd0) state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
    end
  end

`ifdef SHIFT_SEQ_ILLEGAL_FLAG_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (flush) illegal_d = 1'b0;
    else if (accept) illegal_d = !is_shift_op(in_op);
    else if ((state_q == DONE) && out_ready) illegal_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign out_illegal = illegal_q;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed vector bench running STEP=1 and STEP=4 sequencers side by side
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_ILLEGAL_FLAG_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready;
  logic [3:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;

  logic        in_ready1, busy1, out_valid1, out_illegal1;
  logic [31:0] out_data1;
  logic        in_ready4, busy4, out_valid4, out_illegal4;
  logic [31:0] out_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_op(in_op), .in_data(in_data), .in_shamt(in_shamt), .flush(flush),
    .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_illegal(out_illegal1)
  );

  shift_seq_ctrl #(.STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_data(in_data), .in_shamt(in_shamt), .flush(flush),
    .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_illegal(out_illegal4)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
    logic        ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic release_both(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov1_after"}, {31'd0, out_valid1}, 32'd0);
    chk({tag, "_ov4_after"}, {31'd0, out_valid4}, 32'd0);
    chk({tag, "_ill1_after"}, {31'd0, out_illegal1}, 32'd0);
    chk({tag, "_rdy1_after"}, {31'd0, in_ready1}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int c, lat1, lat4;
    logic got1, got4, il1, il4, bad;
    logic [31:0] d1, d4;
    got1 = 1'b0; got4 = 1'b0; bad = 1'b0;
    lat1 = 0; lat4 = 0; d1 = '0; d4 = '0; il1 = 1'b0; il4 = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_op = v.op; in_data = v.data; in_shamt = v.shamt;
    chk({tag, "_rdy_idle"}, {30'd0, in_ready1, in_ready4}, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 1;
    for (int i = 0; i < 60; i++) begin
      if (!got1 && out_valid1) begin got1 = 1'b1; lat1 = c; d1 = out_data1; il1 = out_illegal1; end
      if (!got4 && out_valid4) begin got4 = 1'b1; lat4 = c; d4 = out_data4; il4 = out_illegal4; end
      if ((busy1 && in_ready1) || (busy4 && in_ready4)) bad = 1'b1;
      if (got1 && got4) break;
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_got1"}, {31'd0, got1}, 32'd1);
    chk({tag, "_got4"}, {31'd0, got4}, 32'd1);
    chk({tag, "_data1"}, d1, v.exp);
    chk({tag, "_data4"}, d4, v.exp);
    chk({tag, "_lat1"}, 32'(lat1), 32'(v.lat1));
    chk({tag, "_lat4"}, 32'(lat4), 32'(v.lat4));
    chk({tag, "_ill1"}, {31'd0, il1}, {31'd0, v.ill & ILL_EN});
    chk({tag, "_ill4"}, {31'd0, il4}, {31'd0, v.ill & ILL_EN});
    chk({tag, "_rdy_busy"}, {31'd0, bad}, 32'd0);
    chk({tag, "_hold4"}, out_data4, v.exp);
    release_both(tag);
  endtask

  initial begin
    logic saw;
    vec_t v;

    vecs[0]  = '{4'b0101, 32'h0000_0001, 5'd4,  32'h0000_0010, 5,  2, 1'b0};
    vecs[1]  = '{4'b0111, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32, 9, 1'b0};
    vecs[2]  = '{4'b0111, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 32, 9, 1'b0};
    vecs[3]  = '{4'b0110, 32'hF000_0000, 5'd7,  32'h01E0_0000, 8,  3, 1'b0};
    vecs[4]  = '{4'b0101, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  1, 1'b0};
    vecs[5]  = '{4'b0000, 32'h1234_5678, 5'd5,  32'h0000_0000, 1,  1, 1'b1};
    vecs[6]  = '{4'b0111, 32'h8000_0000, 5'd7,  32'hFF00_0000, 8,  3, 1'b0};
    vecs[7]  = '{4'b0101, 32'h0000_000F, 5'd31, 32'h8000_0000, 32, 9, 1'b0};
    vecs[8]  = '{4'b0110, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 17, 5, 1'b0};
    vecs[9]  = '{4'b0111, 32'h8000_F000, 5'd17, 32'hFFFF_C000, 18, 6, 1'b0};
    vecs[10] = '{4'b0111, 32'h4000_0000, 5'd4,  32'h0400_0000, 5,  2, 1'b0};
    vecs[11] = '{4'b1111, 32'h0000_AAAA, 5'd3,  32'h0000_0000, 1,  1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_op = '0; in_data = '0; in_shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {30'd0, busy1, busy4}, 32'd0);
    chk("rst_ov", {30'd0, out_valid1, out_valid4}, 32'd0);
    chk("rst_data1", out_data1, 32'd0);
    chk("rst_data4", out_data4, 32'd0);
    chk("rst_ill", {30'd0, out_illegal1, out_illegal4}, 32'd0);
    chk("rst_rdy", {30'd0, in_ready1, in_ready4}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // result held while consumer stalls; no overlap with the release cycle
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0101; in_data = 32'hDEAD_BEEF; in_shamt = 5'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_ov", {31'd0, out_valid1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_data_%0d", i), out_data1, 32'hDEAD_BEEF);
      chk($sformatf("hold_rdy_%0d", i), {31'd0, in_ready1}, 32'd0);
      chk($sformatf("hold_ov_%0d", i), {31'd0, out_valid1}, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_op = 4'b0101; in_data = 32'h0000_0001; in_shamt = 5'd1;
    chk("hold_rdy_rel", {31'd0, in_ready1}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_not_taken", {30'd0, busy1, out_valid1}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_next_taken", {31'd0, busy1}, 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid1 && out_valid4) begin saw = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("hold_next_done", {31'd0, saw}, 32'd1);
    chk("hold_next_data", out_data1, 32'h0000_0002);
    release_both("hold");

    // flush during the fifth iteration, with a request presented alongside it
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0101; in_data = 32'h0000_0001; in_shamt = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      saw = saw | out_valid1 | out_valid4;
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 4'b0110; in_data = 32'h8000_0000; in_shamt = 5'd3;
    chk("flush_rdy", {30'd0, in_ready1, in_ready4}, 32'd0);
    @(posedge clk); #1;
    saw = saw | out_valid1 | out_valid4;
    chk("flush_idle", {30'd0, busy1, busy4}, 32'd0);
    @(posedge clk); #1;
    saw = saw | out_valid1 | out_valid4;
    chk("flush_no_accept", {30'd0, busy1, busy4}, 32'd0);
    chk("flush_no_valid", {31'd0, saw}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    v = '{4'b0110, 32'h8000_0000, 5'd3, 32'h1000_0000, 4, 2, 1'b0};
    run_vec("post_flush", v);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0101; in_data = 32'h0000_0001; in_shamt = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("arst_pre_busy", {30'd0, busy1, busy4}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {30'd0, busy1, busy4}, 32'd0);
    chk("arst_ov", {30'd0, out_valid1, out_valid4}, 32'd0);
    chk("arst_data1", out_data1, 32'd0);
    chk("arst_data4", out_data4, 32'd0);
    chk("arst_ill", {30'd0, out_illegal1, out_illegal4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_arst", vecs[6]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
